// File: rtl/multicycle_controller.sv
// Control FSM for the multicycle RV32I core: sequences fetch/decode/execute/memory/writeback
// over a shared ALU and unified memory, driving all datapath selects and strobes.
module multicycle_controller (
    input  logic       clk,
    input  logic       rst,
    input  logic [6:0] Op,
    input  logic       Zero,
    input  logic       MemReady,
    output logic       PCWrite,
    output logic       AdrSrc,
    output logic       MemWrite,
    output logic       IRWrite,
    output logic [1:0] ResultSrc,
    output logic [1:0] ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic [1:0] ALUOp,
    output logic [1:0] ImmSrc,
    output logic       RegWrite,
    output logic       IllegalOp,
    output logic       InstrDone
);

    localparam logic [6:0] OP_LW   = 7'b0000011;
    localparam logic [6:0] OP_SW   = 7'b0100011;
    localparam logic [6:0] OP_R    = 7'b0110011;
    localparam logic [6:0] OP_I    = 7'b0010011;
    localparam logic [6:0] OP_BEQ  = 7'b1100011;
    localparam logic [6:0] OP_JAL  = 7'b1101111;

    typedef enum logic [3:0] {
        FETCH, DECODE, MEMADR, MEMREAD, MEMWB, MEMWRITE,
        EXECR, EXECI, ALUWB, BEQ, JAL
    } state_t;

    state_t state;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= FETCH;
        end else begin
            case (state)
                FETCH:    if (MemReady) state <= DECODE;
                DECODE: begin
                    case (Op)
                        OP_LW, OP_SW: state <= MEMADR;
                        OP_R:         state <= EXECR;
                        OP_I:         state <= EXECI;
                        OP_BEQ:       state <= BEQ;
                        OP_JAL:       state <= JAL;
                        default:      state <= FETCH;
                    endcase
                end
                MEMADR:   state <= (Op == OP_LW) ? MEMREAD : MEMWRITE;
                MEMREAD:  if (MemReady) state <= MEMWB;
                MEMWB:    state <= FETCH;
                MEMWRITE: if (MemReady) state <= FETCH;
                EXECR:    state <= ALUWB;
                EXECI:    state <= ALUWB;
                ALUWB:    state <= FETCH;
                BEQ:      state <= FETCH;
                JAL:      state <= ALUWB;
                default:  state <= FETCH;
            endcase
        end
    end

    always_comb begin
        case (Op)
            OP_SW:   ImmSrc = 2'b01;
            OP_BEQ:  ImmSrc = 2'b10;
            OP_JAL:  ImmSrc = 2'b11;
            default: ImmSrc = 2'b00;
        endcase
    end

    always_comb begin
        PCWrite   = 1'b0;
        AdrSrc    = 1'b0;
        MemWrite  = 1'b0;
        IRWrite   = 1'b0;
        ResultSrc = 2'b00;
        ALUSrcA   = 2'b00;
        ALUSrcB   = 2'b00;
        ALUOp     = 2'b00;
        RegWrite  = 1'b0;
        IllegalOp = 1'b0;
        InstrDone = 1'b0;
        case (state)
            FETCH: begin
                ALUSrcB   = 2'b10;
                ResultSrc = 2'b10;
                IRWrite   = MemReady;
                PCWrite   = MemReady;
            end
            DECODE: begin
                ALUSrcA = 2'b01;
                ALUSrcB = 2'b01;
                case (Op)
                    OP_LW, OP_SW, OP_R, OP_I, OP_BEQ, OP_JAL: ;
                    default: begin
                        IllegalOp = 1'b1;
                        InstrDone = 1'b1;
                    end
                endcase
            end
            MEMADR: begin
                ALUSrcA = 2'b10;
                ALUSrcB = 2'b01;
            end
            MEMREAD:  AdrSrc = 1'b1;
            MEMWB: begin
                ResultSrc = 2'b01;
                RegWrite  = 1'b1;
                InstrDone = 1'b1;
            end
            MEMWRITE: begin
                AdrSrc    = 1'b1;
                MemWrite  = 1'b1;
                InstrDone = MemReady;
            end
            EXECR: begin
                ALUSrcA = 2'b10;
                ALUOp   = 2'b10;
            end
            EXECI: begin
                ALUSrcA = 2'b10;
                ALUSrcB = 2'b01;
                ALUOp   = 2'b10;
            end
            ALUWB: begin
                RegWrite  = 1'b1;
                InstrDone = 1'b1;
            end
            BEQ: begin
                ALUSrcA   = 2'b10;
                ALUOp     = 2'b01;
                PCWrite   = Zero;
                InstrDone = 1'b1;
            end
            JAL: begin
                ALUSrcA = 2'b01;
                ALUSrcB = 2'b10;
                PCWrite = 1'b1;
            end
            default: ;
        endcase
        // Reset parks the FSM in FETCH; suppress its MemReady-driven strobes too.
        if (rst) begin
            PCWrite   = 1'b0;
            IRWrite   = 1'b0;
            MemWrite  = 1'b0;
            RegWrite  = 1'b0;
            IllegalOp = 1'b0;
            InstrDone = 1'b0;
        end
    end

endmodule

// File: doc/multicycle_controller.md
# multicycle_controller

Control FSM for the multicycle RV32I core. Each instruction is sequenced through fetch, decode, execute, memory and writeback steps over a single shared ALU and a unified instruction/data memory. The block decodes the 7-bit opcode and drives every datapath mux select and write strobe each cycle. The ALU decoder stays a separate combinational block fed by ALUOp.

## Interface
Parameters:
- none (encodings fixed by RV32I subset: lw, sw, R-type, I-type ALU, beq, jal)

Ports:
- clk  in  1  core clock; all state updates on rising edge
- rst  in  1  asynchronous, active-high reset
- Op  in  7  opcode field, from instruction register (valid from DECODE onward)
- Zero  in  1  ALU zero flag
- MemReady  in  1  memory handshake; access completes in a cycle where MemReady=1
- PCWrite  out  1  PC register enable
- AdrSrc  out  1  memory address select: 0=PC, 1=ALUOut
- MemWrite  out  1  memory write strobe
- IRWrite  out  1  instruction register and OldPC enable
- ResultSrc  out  2  00=ALUOut, 01=ReadData, 10=ALUResult
- ALUSrcA  out  2  00=PC, 01=OldPC, 10=RD1
- ALUSrcB  out  2  00=RD2, 01=ImmExt, 10=constant 4
- ALUOp  out  2  00=add, 01=sub/compare, 10=funct-decoded
- ImmSrc  out  2  combinational from Op: lw/I-type 00, sw 01, beq 10, jal 11, other 00
- RegWrite  out  1  register file write strobe
- IllegalOp  out  1  one-cycle pulse: unsupported opcode detected
- InstrDone  out  1  one-cycle pulse on final cycle of each instruction

## Operation
- States: FETCH, DECODE, MEMADR, MEMREAD, MEMWB, MEMWRITE, EXECR, EXECI, ALUWB, BEQ, JAL. Encoding is free; 4-bit register.
- Outputs not listed for a state are 0.
- FETCH:
  - AdrSrc=0, ALUSrcA=00, ALUSrcB=10, ALUOp=00, ResultSrc=10.
  - IRWrite=PCWrite=MemReady.
  - Stay while MemReady=0; else -> DECODE.
- DECODE:
  - ALUSrcA=01, ALUSrcB=01, ALUOp=00 (branch/jump target into ALUOut).
  - Next state by Op:
    - 0000011 or 0100011 -> MEMADR
    - 0110011 -> EXECR
    - 0010011 -> EXECI
    - 1100011 -> BEQ
    - 1101111 -> JAL
    - any other -> FETCH with IllegalOp=1 and InstrDone=1.
- MEMADR:
  - ALUSrcA=10, ALUSrcB=01, ALUOp=00.
  - -> MEMREAD if Op=0000011, else MEMWRITE.
- MEMREAD:
  - AdrSrc=1.
  - Stay while MemReady=0; else -> MEMWB.
- MEMWB:
  - ResultSrc=01, RegWrite=1, InstrDone=1.
  - -> FETCH.
- MEMWRITE:
  - AdrSrc=1, MemWrite=1.
  - Stay while MemReady=0; else -> FETCH with InstrDone=1 in the completing cycle.
- EXECR:
  - ALUSrcA=10, ALUSrcB=00, ALUOp=10.
  - -> ALUWB.
- EXECI:
  - ALUSrcA=10, ALUSrcB=01, ALUOp=10.
  - -> ALUWB.
- ALUWB:
  - ResultSrc=00, RegWrite=1, InstrDone=1.
  - -> FETCH.
- BEQ:
  - ALUSrcA=10, ALUSrcB=00, ALUOp=01, ResultSrc=00, PCWrite=Zero, InstrDone=1.
  - -> FETCH.
- JAL:
  - ALUSrcA=01, ALUSrcB=10, ALUOp=00, ResultSrc=00, PCWrite=1.
  - -> ALUWB (writes OldPC+4 to rd).
- Op is sampled only in DECODE and MEMADR. Changes to Op in other states have no effect.

## Timing
- Reset:
  - rst=1 forces state to FETCH immediately, independent of clk.
  - While rst=1, PCWrite, IRWrite, MemWrite, RegWrite, IllegalOp and InstrDone are 0.
  - Select outputs take FETCH values: AdrSrc=0, ALUSrcA=00, ALUSrcB=10, ALUOp=00, ResultSrc=10.
  - First fetch can complete on the first rising edge after rst deasserts.
- Reset mid-instruction aborts it. No partial RegWrite or MemWrite is issued after rst rises.
- Output timing:
  - All outputs are combinational from state, plus Op (ImmSrc), MemReady (FETCH strobes) and Zero (BEQ).
  - No registered outputs; no extra latency.
- Cycle counts with MemReady held 1:
  - lw 5
  - sw 4
  - R-type 4
  - I-type 4
  - jal 4
  - beq 3
  - illegal 2
- Each cycle with MemReady=0 in FETCH, MEMREAD or MEMWRITE adds exactly one cycle.
- Strobe behaviour during waits:
  - MemWrite stays asserted throughout MEMWRITE wait cycles.
  - IRWrite and PCWrite stay 0 until MemReady=1.
- MemReady is ignored outside FETCH, MEMREAD and MEMWRITE.
- InstrDone: exactly one pulse per instruction, never in two consecutive cycles.

## Test plan
- Reset and first fetch:
  - Assert rst mid-cycle with state=EXECR -> state=FETCH without a clock edge; all strobes 0.
  - Release rst with MemReady=1 -> IRWrite=1 and PCWrite=1 on the next cycle.
- lw with wait:
  - Op=0000011, MemReady=0 for 2 cycles in MEMREAD -> sequence FETCH, DECODE, MEMADR, MEMREAD×3, MEMWB.
  - In MEMWB: RegWrite=1, ResultSrc=01, InstrDone=1.
  - Total 7 cycles.
- sw:
  - Op=0100011, MemReady=1 -> MemWrite=1 and AdrSrc=1 for exactly 1 cycle; RegWrite never 1.
  - ImmSrc=01 in DECODE.
  - 4 cycles.
- beq:
  - Op=1100011, Zero=1 -> PCWrite=1 in BEQ with ALUOp=01.
  - Repeat with Zero=0 -> PCWrite=0; RegWrite never asserted.
  - 3 cycles each.
- jal:
  - Op=1101111 -> JAL: PCWrite=1, ALUSrcA=01, ALUSrcB=10.
  - Then ALUWB: RegWrite=1.
  - ImmSrc=11; 4 cycles.
- Illegal opcode:
  - Op=1111111 -> IllegalOp=1 and InstrDone=1 in DECODE, next state FETCH.
  - No RegWrite, MemWrite or PCWrite outside FETCH.
